// File: rtl/xnor_popcount_seq.sv
// Bit-serial XNOR popcount: captures two WIDTH-bit words, streams them LSB-first
// through one shared xnor_gate, and reports the number of matching bit positions.

module xnor_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = ~(a_i ^ b_i);
endmodule

module xnor_popcount_seq #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             equal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [CNT_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               equal_q, equal_d;

    logic               xnor_bit_c;
    logic [CNT_W-1:0]   sum_c;
    logic               last_c;
    logic               load_c;

    xnor_gate u_xnor (
        .a_i (sa_q[0]),
        .b_i (sb_q[0]),
        .y_o (xnor_bit_c)
    );

    assign sum_c  = acc_q + CNT_W'(xnor_bit_c);
    assign last_c = (bit_idx_q == CNT_W'(WIDTH - 1));
    // A new request is only accepted when not mid-stream.
    assign load_c = start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        bit_idx_d   = bit_idx_q;
        acc_d       = acc_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        match_cnt_d = match_cnt_q;
        equal_d     = equal_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (load_c) begin
                    state_d   = RUN;
                    sa_d      = a_word;
                    sb_d      = b_word;
                    bit_idx_d = '0;
                    acc_d     = '0;
                    busy_d    = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end
            RUN: begin
                acc_d     = sum_c;
                sa_d      = sa_q >> 1;
                sb_d      = sb_q >> 1;
                bit_idx_d = bit_idx_q + CNT_W'(1);
                busy_d    = 1'b1;
                if (last_c) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    match_cnt_d = sum_c;
                    equal_d     = (sum_c == CNT_W'(WIDTH));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            bit_idx_q   <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            match_cnt_q <= '0;
            equal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            bit_idx_q   <= bit_idx_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            match_cnt_q <= match_cnt_d;
            equal_q     <= equal_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = match_cnt_q;
    assign equal     = equal_q;

endmodule

// File: tb/tb_xnor_popcount_seq.sv
// Scoreboard bench for xnor_popcount_seq: stimulus pushes expected results,
// an independent monitor pops and compares on every done pulse.

module tb_xnor_popcount_seq;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a_word;
    logic [W-1:0]  b_word;
    logic          busy;
    logic          done;
    logic [CW-1:0] match_cnt;
    logic          equal;

    logic [CW:0]   sb_q[$];
    int            checks;
    int            errors;
    int            ndone;
    int            npush;
    logic [CW-1:0] last_cnt;

    xnor_popcount_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_word    (a_word),
        .b_word    (b_word),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt),
        .equal     (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [CW-1:0] cnt);
        sb_q.push_back({cnt, (cnt == CW'(W))});
        npush++;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                ndone++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 with no request outstanding, required none");
                end else begin
                    logic [CW:0] e;
                    e = sb_q.pop_front();
                    chk("match_cnt", int'(match_cnt), int'(e[CW:1]));
                    chk("equal", int'(equal), int'(e[0]));
                    chk("busy_at_done", int'(busy), 0);
                end
            end
        end
    end

    // Called at the negedge of the first cycle after the accepting edge.
    task automatic wait_done(input string name, input bit hold, output int k);
        int busy_cycles;
        busy_cycles = 0;
        k = 1;
        while (!done && k < 40) begin
            if (busy) busy_cycles++;
            if (k == 4) chk({name, "_cnt_held"}, int'(match_cnt), int'(last_cnt));
            if (hold && k == 3) begin
                a_word = 8'hFF;
                b_word = 8'hFF;
            end
            @(negedge clk);
            k++;
        end
        if (hold) start = 1'b0;
        chk({name, "_done_seen"}, int'(done), 1);
        chk({name, "_latency"}, k, W + 1);
        chk({name, "_busy_cycles"}, busy_cycles, W);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [CW-1:0] exp);
        @(negedge clk);
        start  = 1'b1;
        a_word = a;
        b_word = b;
        push_exp(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int k;
        int late_done;
        checks = 0; errors = 0; ndone = 0; npush = 0;
        last_cnt = '0;
        rst_n = 1'b0; start = 1'b0; a_word = '0; b_word = '0;

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(match_cnt), 0);
        chk("rst_equal", int'(equal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        issue(8'hFF, 8'hFF, 4'd8);
        wait_done("ff_ff", 1'b0, k);
        last_cnt = 4'd8;

        issue(8'hA5, 8'h5A, 4'd0);
        wait_done("a5_5a", 1'b0, k);
        last_cnt = 4'd0;

        issue(8'hF0, 8'hF3, 4'd6);
        wait_done("f0_f3", 1'b0, k);
        last_cnt = 4'd6;

        // start held through RUN, operands swapped mid-run
        @(negedge clk);
        start  = 1'b1;
        a_word = 8'h0F;
        b_word = 8'h00;
        push_exp(4'd4);
        @(negedge clk);
        wait_done("held", 1'b1, k);
        last_cnt = 4'd4;
        @(negedge clk);
        chk("held_idle_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("held_no_rerun", int'(busy), 0);

        // back-to-back: start asserted during the DONE cycle
        issue(8'h33, 8'h31, 4'd7);
        wait_done("b2b_first", 1'b0, k);
        last_cnt = 4'd7;
        start  = 1'b1;
        a_word = 8'h0F;
        b_word = 8'h0F;
        push_exp(4'd8);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_rise", int'(busy), 1);
        wait_done("b2b_second", 1'b0, k);
        last_cnt = 4'd8;

        // asynchronous reset in cycle T+4 aborts the run
        @(negedge clk);
        start  = 1'b1;
        a_word = 8'h00;
        b_word = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_cnt", int'(match_cnt), 0);
        chk("abort_equal", int'(equal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        chk("abort_no_done", late_done, 0);
        last_cnt = 4'd0;

        issue(8'hF0, 8'hF3, 4'd6);
        wait_done("post_rst", 1'b0, k);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        chk("done_count", ndone, npush);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
